multi_fault_injector: RTL and testbench
=======================================

MULTI_FAULT_INJECTOR -- requirements
Module: multi_fault_injector

Interface
REQ-001 SHALL have parameter ROW_ADDR_BITS, default 4, logical row address width.
REQ-002 SHALL have parameter COL_ADDR_BITS, default 4, logical column address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-004 SHALL have parameter NUM_FAULTS, default 4, number of independent fault slots (1..16).
REQ-005 SHALL have parameter CNT_WIDTH, default 8, per-slot hit counter width.
REQ-006 Ports SHALL be (name  dir  width  meaning); one clock, reset asynchronous active-low:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 wr_en / rd_en  in  1 each  MBIST write / read strobe
 row_addr / col_addr  in  ROW_ADDR_BITS / COL_ADDR_BITS  logical access address
 data_in  in  DATA_WIDTH  MBIST write data
 data_out_mem  in  DATA_WIDTH  raw read data from memory
 data_out_faulted  out  DATA_WIDTH  read data presented to MBIST
 global_en  in  1  master injection enable
 cfg_we  in  1  slot configuration write strobe
 cfg_slot  in  $clog2(NUM_FAULTS) (min 1)  slot index
 cfg_type  in  3  NONE=0 SAF=1 TF=2 AF=3 CF=4
 cfg_scope  in  2  CELL=0 ROW=1 COL=2 (3 treated as CELL)
 cfg_row / cfg_col  in  ROW/COL_ADDR_BITS  target (victim) coordinates
 cfg_aggr_row / cfg_aggr_col  in  ROW/COL_ADDR_BITS  aggressor coordinates (AF, CF)
 cfg_bit  in  $clog2(DATA_WIDTH)  affected bit
 cfg_val  in  1  SAF stuck value; TF failing direction (1=slow-to-rise, 0=slow-to-fall)
 fault_active  out  NUM_FAULTS  bit i = slot i type != NONE
 hit_cnt  out  NUM_FAULTS*CNT_WIDTH  slot i counter at [i*CNT_WIDTH +: CNT_WIDTH]

Function
REQ-007 cfg_we SHALL latch all cfg_* fields into slot cfg_slot at the clock edge and clear that slot's dynamic state (TF shadow/valid, AF alias/valid, CF pending, counter); cfg_slot >= NUM_FAULTS SHALL be ignored.
REQ-008 Slot hit: CELL = row and col match, ROW = row match, COL = col match; TF, AF, CF SHALL always use CELL scope.
REQ-009 data_out_faulted SHALL be combinational from data_out_mem and registered slot state (zero latency); slots applied in ascending index, higher index wins on a shared bit.
REQ-010 SAF: read hit SHALL force cfg_bit to cfg_val.
REQ-011 TF: write hit SHALL update a 1-bit shadow to data_in[cfg_bit], except when shadow valid and the write is the failing transition (0->1 for cfg_val=1, 1->0 for cfg_val=0), which leaves it unchanged; first write always succeeds and sets valid; read hit with valid shadow SHALL return shadow at cfg_bit.
REQ-012 AF: write at aggressor SHALL capture data_in into alias register and set alias valid; read at target with alias valid SHALL return the full alias word.
REQ-013 CF (inversion coupling): each write at aggressor SHALL toggle pending; read at victim with pending set SHALL invert cfg_bit; write at victim SHALL clear pending; aggressor==victim write: clear wins.
REQ-014 Same-cycle read and write: read SHALL use pre-write state; updates visible next cycle; cfg_we coincident with access: access uses old configuration.
REQ-015 global_en=0: data_out_faulted SHALL equal data_out_mem, dynamic state frozen; configuration writes still accepted.
REQ-016 Counter SHALL increment on each rd_en cycle where the slot altered at least one output bit, saturating at all-ones.

Reset
REQ-017 rst_n low SHALL asynchronously set all slot types NONE, all coordinates/fields 0, all dynamic state and counters 0; fault_active=0, hit_cnt=0, data_out_faulted=data_out_mem.
REQ-018 Reset mid-operation SHALL discard pending CF/TF/AF state without producing a faulted cycle.

Configuration
REQ-019 Macro FI_HIT_COUNT_EN defined: counters per REQ-016; undefined: no counter flops, hit_cnt tied to 0.

Structure
REQ-020 Package fi_pkg SHALL hold fault_e (NONE..CF), scope_e (CELL/ROW/COL), and slot configuration struct typedef.
REQ-021 Per-slot logic SHALL be sub-module fi_slot, instantiated NUM_FAULTS times by generate; top performs priority merge.

Verification
REQ-022 SAF slot0 CELL (3,2) bit0 val0; read (3,2) raw 0xFF -> 0xFE, cnt0=1; read (3,3) -> 0xFF.
REQ-023 TF slot1 (1,1) bit7 val1; write 0x00 then 0x80; read raw 0x80 -> 0x00; write 0x00 then read -> bit7=0.
REQ-024 CF slot2 aggr (2,3) victim (3,4) bit0; write aggr; read victim raw 0x00 -> 0x01; write aggr again; read -> 0x00; write aggr, write victim, read -> raw.
REQ-025 AF slot3 aggr (0,0) target (5,5); write 0xA5 at (0,0); read (5,5) raw 0x3C -> 0xA5; global_en=0 -> 0x3C.
REQ-026 SAF on slots 0 and 1 same bit0, vals 0/1; read hit -> bit0=1; 300 hits -> counter 255 (FI_HIT_COUNT_EN); rst_n pulse mid-run -> all outputs reset values.

Source files
------------

// File: rtl/fi_pkg.sv
// Shared types for the multi-slot MBIST fault injector.
// Slot configuration is stored at fixed maximum widths so one struct serves every parameterisation.
package fi_pkg;

    localparam int FI_MAX_ADDR_BITS = 16;
    localparam int FI_MAX_BIT_BITS  = 8;

    typedef enum logic [2:0] {
        FT_NONE = 3'd0,
        FT_SAF  = 3'd1,
        FT_TF   = 3'd2,
        FT_AF   = 3'd3,
        FT_CF   = 3'd4
    } fault_e;

    typedef enum logic [1:0] {
        SC_CELL = 2'd0,
        SC_ROW  = 2'd1,
        SC_COL  = 2'd2
    } scope_e;

    typedef struct packed {
        fault_e                      ftype;
        scope_e                      scope;
        logic [FI_MAX_ADDR_BITS-1:0] row;
        logic [FI_MAX_ADDR_BITS-1:0] col;
        logic [FI_MAX_ADDR_BITS-1:0] aggr_row;
        logic [FI_MAX_ADDR_BITS-1:0] aggr_col;
        logic [FI_MAX_BIT_BITS-1:0]  bit_sel;
        logic                        val;
    } slot_cfg_t;

endpackage

// File: rtl/fi_slot.sv
// One fault slot: holds its configuration and dynamic state (TF shadow, AF alias, CF pending)
// and reports which output bits it wants to override on the current read.
module fi_slot
    import fi_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        global_en,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [FI_MAX_ADDR_BITS-1:0] acc_row,
    input  logic [FI_MAX_ADDR_BITS-1:0] acc_col,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic [DATA_WIDTH-1:0]       data_out_mem,
    input  logic                        cfg_we,
    input  slot_cfg_t                   cfg_new,
    output logic                        fault_active,
    output logic [DATA_WIDTH-1:0]       ovr_mask,
    output logic [DATA_WIDTH-1:0]       ovr_data
);

    slot_cfg_t             cfg_q, cfg_d;
    logic                  tf_shadow_q, tf_shadow_d;
    logic                  tf_valid_q, tf_valid_d;
    logic [DATA_WIDTH-1:0] af_alias_q, af_alias_d;
    logic                  af_valid_q, af_valid_d;
    logic                  cf_pending_q, cf_pending_d;

    logic [DATA_WIDTH-1:0] bit_mask;
    logic                  cell_hit, scoped_hit, aggr_hit, din_bit, tf_failing;

    always_comb begin
        bit_mask   = DATA_WIDTH'(1) << cfg_q.bit_sel;
        din_bit    = |(data_in & bit_mask);
        cell_hit   = (acc_row == cfg_q.row) && (acc_col == cfg_q.col);
        aggr_hit   = (acc_row == cfg_q.aggr_row) && (acc_col == cfg_q.aggr_col);
        case (cfg_q.scope)
            SC_ROW:  scoped_hit = (acc_row == cfg_q.row);
            SC_COL:  scoped_hit = (acc_col == cfg_q.col);
            default: scoped_hit = cell_hit;
        endcase
        // A transition fault only blocks the failing edge once the cell holds a known value.
        tf_failing = tf_valid_q && (tf_shadow_q != din_bit) && (din_bit == cfg_q.val);
    end

    always_comb begin
        ovr_mask = '0;
        ovr_data = '0;
        if (global_en && rd_en) begin
            case (cfg_q.ftype)
                FT_SAF: if (scoped_hit) begin
                    ovr_mask = bit_mask;
                    ovr_data = cfg_q.val ? bit_mask : '0;
                end
                FT_TF: if (cell_hit && tf_valid_q) begin
                    ovr_mask = bit_mask;
                    ovr_data = tf_shadow_q ? bit_mask : '0;
                end
                FT_AF: if (cell_hit && af_valid_q) begin
                    ovr_mask = '1;
                    ovr_data = af_alias_q;
                end
                FT_CF: if (cell_hit && cf_pending_q) begin
                    ovr_mask = bit_mask;
                    ovr_data = ~data_out_mem & bit_mask;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_d        = cfg_q;
        tf_shadow_d  = tf_shadow_q;
        tf_valid_d   = tf_valid_q;
        af_alias_d   = af_alias_q;
        af_valid_d   = af_valid_q;
        cf_pending_d = cf_pending_q;
        if (cfg_we) begin
            cfg_d        = cfg_new;
            tf_shadow_d  = 1'b0;
            tf_valid_d   = 1'b0;
            af_alias_d   = '0;
            af_valid_d   = 1'b0;
            cf_pending_d = 1'b0;
        end else if (global_en && wr_en) begin
            case (cfg_q.ftype)
                FT_TF: if (cell_hit && !tf_failing) begin
                    tf_shadow_d = din_bit;
                    tf_valid_d  = 1'b1;
                end
                FT_AF: if (aggr_hit) begin
                    af_alias_d = data_in;
                    af_valid_d = 1'b1;
                end
                // A victim write restores the cell, so it overrides a coincident aggressor toggle.
                FT_CF: begin
                    if (cell_hit)      cf_pending_d = 1'b0;
                    else if (aggr_hit) cf_pending_d = ~cf_pending_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q        <= '0;
            tf_shadow_q  <= 1'b0;
            tf_valid_q   <= 1'b0;
            af_alias_q   <= '0;
            af_valid_q   <= 1'b0;
            cf_pending_q <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            tf_shadow_q  <= tf_shadow_d;
            tf_valid_q   <= tf_valid_d;
            af_alias_q   <= af_alias_d;
            af_valid_q   <= af_valid_d;
            cf_pending_q <= cf_pending_d;
        end
    end

    assign fault_active = (cfg_q.ftype != FT_NONE);

endmodule

// File: rtl/multi_fault_injector.sv
// MBIST read-path fault injector with NUM_FAULTS slots merged by ascending priority.
// Per-slot hit counters exist only when FI_HIT_COUNT_EN is defined; otherwise hit_cnt is 0.
module multi_fault_injector
    import fi_pkg::*;
#(
    parameter int ROW_ADDR_BITS = 4,
    parameter int COL_ADDR_BITS = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_FAULTS    = 4,
    parameter int CNT_WIDTH     = 8,
    localparam int SLOT_W       = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [ROW_ADDR_BITS-1:0]        row_addr,
    input  logic [COL_ADDR_BITS-1:0]        col_addr,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [DATA_WIDTH-1:0]           data_out_mem,
    output logic [DATA_WIDTH-1:0]           data_out_faulted,
    input  logic                            global_en,
    input  logic                            cfg_we,
    input  logic [SLOT_W-1:0]               cfg_slot,
    input  logic [2:0]                      cfg_type,
    input  logic [1:0]                      cfg_scope,
    input  logic [ROW_ADDR_BITS-1:0]        cfg_row,
    input  logic [COL_ADDR_BITS-1:0]        cfg_col,
    input  logic [ROW_ADDR_BITS-1:0]        cfg_aggr_row,
    input  logic [COL_ADDR_BITS-1:0]        cfg_aggr_col,
    input  logic [BIT_W-1:0]                cfg_bit,
    input  logic                            cfg_val,
    output logic [NUM_FAULTS-1:0]           fault_active,
    output logic [NUM_FAULTS*CNT_WIDTH-1:0] hit_cnt
);

    logic [FI_MAX_ADDR_BITS-1:0] acc_row, acc_col;
    slot_cfg_t                   cfg_new;
    logic [NUM_FAULTS-1:0]       slot_we;
    logic [DATA_WIDTH-1:0]       slot_mask [NUM_FAULTS];
    logic [DATA_WIDTH-1:0]       slot_data [NUM_FAULTS];
    logic [DATA_WIDTH-1:0]       chain     [NUM_FAULTS+1];

    // Out-of-range type codes are stored as NONE so fault_active never reports a do-nothing slot.
    always_comb begin
        acc_row                           = '0;
        acc_col                           = '0;
        acc_row[ROW_ADDR_BITS-1:0]        = row_addr;
        acc_col[COL_ADDR_BITS-1:0]        = col_addr;
        cfg_new                           = '0;
        cfg_new.ftype                     = (cfg_type <= 3'd4) ? fault_e'(cfg_type) : FT_NONE;
        cfg_new.scope                     = scope_e'(cfg_scope);
        cfg_new.row[ROW_ADDR_BITS-1:0]    = cfg_row;
        cfg_new.col[COL_ADDR_BITS-1:0]    = cfg_col;
        cfg_new.aggr_row[ROW_ADDR_BITS-1:0] = cfg_aggr_row;
        cfg_new.aggr_col[COL_ADDR_BITS-1:0] = cfg_aggr_col;
        cfg_new.bit_sel[BIT_W-1:0]        = cfg_bit;
        cfg_new.val                       = cfg_val;
    end

    for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_slot
        assign slot_we[i] = cfg_we && (cfg_slot == SLOT_W'(i));

        fi_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .global_en   (global_en),
            .wr_en       (wr_en),
            .rd_en       (rd_en),
            .acc_row     (acc_row),
            .acc_col     (acc_col),
            .data_in     (data_in),
            .data_out_mem(data_out_mem),
            .cfg_we      (slot_we[i]),
            .cfg_new     (cfg_new),
            .fault_active(fault_active[i]),
            .ovr_mask    (slot_mask[i]),
            .ovr_data    (slot_data[i])
        );
    end

    // chain[i] is the word entering slot i, so later slots overwrite earlier ones on shared bits.
    always_comb begin
        chain[0] = data_out_mem;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            chain[i+1] = (chain[i] & ~slot_mask[i]) | (slot_data[i] & slot_mask[i]);
        end
        data_out_faulted = chain[NUM_FAULTS];
    end

`ifdef FI_HIT_COUNT_EN
    for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 altered;

        always_comb begin
            altered = |((chain[i] ^ slot_data[i]) & slot_mask[i]);
            cnt_d   = cnt_q;
            if (slot_we[i])                  cnt_d = '0;
            else if (altered && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign hit_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_fault_injector.sv
// Scoreboard bench for multi_fault_injector: expected read words are queued as reads are driven
// and compared on the falling edge while the read is presented.
module tb_multi_fault_injector;

`ifdef FI_HIT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_SAF  = 3'd1;
    localparam logic [2:0] T_TF   = 3'd2;
    localparam logic [2:0] T_AF   = 3'd3;
    localparam logic [2:0] T_CF   = 3'd4;
    localparam logic [1:0] S_CELL = 2'd0;
    localparam logic [1:0] S_ROW  = 2'd1;
    localparam logic [1:0] S_COL  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [3:0]  row_addr, col_addr;
    logic [7:0]  data_in, data_out_mem, data_out_faulted;
    logic        global_en;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic [2:0]  cfg_type;
    logic [1:0]  cfg_scope;
    logic [3:0]  cfg_row, cfg_col, cfg_aggr_row, cfg_aggr_col;
    logic [2:0]  cfg_bit;
    logic        cfg_val;
    logic [3:0]  fault_active;
    logic [31:0] hit_cnt;

    typedef struct {
        string      tag;
        logic [7:0] expVal;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    int       errorCount = 0;
    int       checkCount = 0;

    multi_fault_injector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .row_addr        (row_addr),
        .col_addr        (col_addr),
        .data_in         (data_in),
        .data_out_mem    (data_out_mem),
        .data_out_faulted(data_out_faulted),
        .global_en       (global_en),
        .cfg_we          (cfg_we),
        .cfg_slot        (cfg_slot),
        .cfg_type        (cfg_type),
        .cfg_scope       (cfg_scope),
        .cfg_row         (cfg_row),
        .cfg_col         (cfg_col),
        .cfg_aggr_row    (cfg_aggr_row),
        .cfg_aggr_col    (cfg_aggr_col),
        .cfg_bit         (cfg_bit),
        .cfg_val         (cfg_val),
        .fault_active    (fault_active),
        .hit_cnt         (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Read words are compared mid-cycle, while the combinational output is stable.
    always @(negedge clk) begin
        if (rst_n && rd_en) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnderflow", 32'(sbQueue.size()), 32'd1);
            end else begin
                sbEntry_t e;
                e = sbQueue.pop_front();
                checkOutput(e.tag, {24'd0, data_out_faulted}, {24'd0, e.expVal});
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] row,
                                 input logic [3:0] col, input logic [7:0] din, input logic [7:0] raw);
        @(posedge clk);
        #1;
        cfg_we       = 1'b0;
        wr_en        = wr;
        rd_en        = rd;
        row_addr     = row;
        col_addr     = col;
        data_in      = din;
        data_out_mem = raw;
    endtask

    task automatic configSlot(input logic [1:0] slot, input logic [2:0] ftype, input logic [1:0] scope,
                              input logic [3:0] row, input logic [3:0] col, input logic [3:0] aRow,
                              input logic [3:0] aCol, input logic [2:0] bitSel, input logic val);
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        cfg_we       = 1'b1;
        cfg_slot     = slot;
        cfg_type     = ftype;
        cfg_scope    = scope;
        cfg_row      = row;
        cfg_col      = col;
        cfg_aggr_row = aRow;
        cfg_aggr_col = aCol;
        cfg_bit      = bitSel;
        cfg_val      = val;
    endtask

    task automatic doWrite(input logic [3:0] row, input logic [3:0] col, input logic [7:0] din);
        applyStimulus(1'b1, 1'b0, row, col, din, 8'h00);
    endtask

    task automatic doRead(input string tag, input logic [3:0] row, input logic [3:0] col,
                          input logic [7:0] raw, input logic [7:0] expVal);
        sbEntry_t e;
        e.tag    = tag;
        e.expVal = expVal;
        sbQueue.push_back(e);
        applyStimulus(1'b0, 1'b1, row, col, 8'h00, raw);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b1; row_addr = 4'd3; col_addr = 4'd2;
        data_in = 8'h00; data_out_mem = 8'h5A; global_en = 1'b1; cfg_we = 1'b0;
        cfg_slot = 2'd0; cfg_type = T_NONE; cfg_scope = S_CELL; cfg_row = 4'd0; cfg_col = 4'd0;
        cfg_aggr_row = 4'd0; cfg_aggr_col = 4'd0; cfg_bit = 3'd0; cfg_val = 1'b0;
        #12;
        checkOutput("rstPassThru", {24'd0, data_out_faulted}, 32'h5A);
        checkOutput("rstActive", {28'd0, fault_active}, 32'h0);
        checkOutput("rstCnt", hit_cnt, 32'h0);
        rd_en = 1'b0;
        #1 rst_n = 1'b1;

        // Stuck-at on a single cell, then row and column scope.
        configSlot(2'd0, T_SAF, S_CELL, 4'd3, 4'd2, 4'd0, 4'd0, 3'd0, 1'b0);
        doRead("safHit", 4'd3, 4'd2, 8'hFF, 8'hFE);
        doRead("safMiss", 4'd3, 4'd3, 8'hFF, 8'hFF);
        idleCycle();
        checkOutput("safActive", {28'd0, fault_active}, 32'h1);
        checkOutput("safCnt0", {24'd0, hit_cnt[7:0]}, CNT_EN ? 32'd1 : 32'd0);

        configSlot(2'd0, T_SAF, S_ROW, 4'd3, 4'd0, 4'd0, 4'd0, 3'd4, 1'b1);
        doRead("safRow", 4'd3, 4'd9, 8'h00, 8'h10);
        doRead("safRowMiss", 4'd4, 4'd0, 8'h00, 8'h00);
        configSlot(2'd0, T_SAF, S_COL, 4'd0, 4'd6, 4'd0, 4'd0, 3'd2, 1'b1);
        doRead("safCol", 4'd1, 4'd6, 8'h00, 8'h04);
        doRead("safColMiss", 4'd6, 4'd1, 8'h00, 8'h00);
        idleCycle();
        checkOutput("safCntReCfg", {24'd0, hit_cnt[7:0]}, CNT_EN ? 32'd1 : 32'd0);

        // Slow-to-rise transition fault on bit 7.
        configSlot(2'd1, T_TF, S_CELL, 4'd1, 4'd1, 4'd0, 4'd0, 3'd7, 1'b1);
        doRead("tfNoShadow", 4'd1, 4'd1, 8'h80, 8'h80);
        doWrite(4'd1, 4'd1, 8'h00);
        doWrite(4'd1, 4'd1, 8'h80);
        doRead("tfRiseBlocked", 4'd1, 4'd1, 8'h80, 8'h00);
        doWrite(4'd1, 4'd1, 8'h00);
        doRead("tfAfterZero", 4'd1, 4'd1, 8'h80, 8'h00);

        // Inversion coupling: aggressor (2,3), victim (3,4), bit 0.
        configSlot(2'd2, T_CF, S_CELL, 4'd3, 4'd4, 4'd2, 4'd3, 3'd0, 1'b0);
        doWrite(4'd2, 4'd3, 8'h11);
        doRead("cfInverted", 4'd3, 4'd4, 8'h00, 8'h01);
        doWrite(4'd2, 4'd3, 8'h22);
        doRead("cfToggledBack", 4'd3, 4'd4, 8'h00, 8'h00);
        doWrite(4'd2, 4'd3, 8'h33);
        doWrite(4'd3, 4'd4, 8'h44);
        doRead("cfVictimClear", 4'd3, 4'd4, 8'h5A, 8'h5A);

        // Address fault: aggressor (0,0) aliases onto target (5,5).
        configSlot(2'd3, T_AF, S_CELL, 4'd5, 4'd5, 4'd0, 4'd0, 3'd0, 1'b0);
        doRead("afNoAlias", 4'd5, 4'd5, 8'h3C, 8'h3C);
        doWrite(4'd0, 4'd0, 8'hA5);
        doRead("afAlias", 4'd5, 4'd5, 8'h3C, 8'hA5);
        idleCycle();
        global_en = 1'b0;
        doRead("afGlobalOff", 4'd5, 4'd5, 8'h3C, 8'h3C);
        doWrite(4'd0, 4'd0, 8'h11);
        idleCycle();
        global_en = 1'b1;
        doRead("afFrozen", 4'd5, 4'd5, 8'h3C, 8'hA5);
        idleCycle();
        checkOutput("allActive", {28'd0, fault_active}, 32'hF);

        // Two stuck-ats on one bit: the higher slot wins; its counter saturates.
        configSlot(2'd0, T_SAF, S_CELL, 4'd7, 4'd7, 4'd0, 4'd0, 3'd0, 1'b0);
        configSlot(2'd1, T_SAF, S_CELL, 4'd7, 4'd7, 4'd0, 4'd0, 3'd0, 1'b1);
        doRead("prioHigh", 4'd7, 4'd7, 8'h00, 8'h01);
        for (int n = 0; n < 300; n++) begin
            doRead("satRead", 4'd7, 4'd7, 8'h00, 8'h01);
        end
        idleCycle();
        checkOutput("satCnt1", {24'd0, hit_cnt[15:8]}, CNT_EN ? 32'd255 : 32'd0);
        checkOutput("satCnt0", {24'd0, hit_cnt[7:0]}, 32'd0);

        // Reset asserted while a faulted read is being presented.
        applyStimulus(1'b0, 1'b1, 4'd7, 4'd7, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstData", {24'd0, data_out_faulted}, 32'h00);
        checkOutput("midRstActive", {28'd0, fault_active}, 32'h0);
        checkOutput("midRstCnt", hit_cnt, 32'h0);
        #2 rst_n = 1'b1;
        doRead("postRstSaf", 4'd7, 4'd7, 8'h00, 8'h00);
        doRead("postRstAf", 4'd5, 4'd5, 8'h3C, 8'h3C);
        idleCycle();
        idleCycle();
        checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
